// File: rtl/ext_int_ctrl_if.sv
// Register bus between software and the external interrupt conditioning stage.
interface ext_int_ctrl_if #(
  parameter int unsigned ADDR_BW = 32,
  parameter int unsigned DATA_BW = 32
);
  logic               bus_en;
  logic               bus_wr;
  logic [ADDR_BW-1:0] bus_addr;
  logic [DATA_BW-1:0] bus_wdata;
  logic               is_priviledge;
  logic [DATA_BW-1:0] bus_rdata;

  modport master (
    output bus_en, bus_wr, bus_addr, bus_wdata, is_priviledge,
    input  bus_rdata
  );

  modport slave (
    input  bus_en, bus_wr, bus_addr, bus_wdata, is_priviledge,
    output bus_rdata
  );
endinterface

// File: rtl/ext_int_ctrl.sv
// External interrupt conditioning: pin synchronisation, per-line level/edge
// mode and polarity, W1C edge flags, and the conditioned requests to the VIC.
module ext_int_ctrl #(
  parameter int unsigned N       = 4,
  parameter logic [31:0] BASE    = 32'hE01F_C140,
  parameter int unsigned ADDR_BW = 32,
  parameter int unsigned DATA_BW = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        ext_pin,
  ext_int_ctrl_if.slave       bus,
  output logic [N-1:0]        vic_eint
);

  localparam logic [ADDR_BW-1:0] A_EXTINT   = ADDR_BW'(BASE);
  localparam logic [ADDR_BW-1:0] A_EXTMODE  = ADDR_BW'(BASE + 32'h8);
  localparam logic [ADDR_BW-1:0] A_EXTPOLAR = ADDR_BW'(BASE + 32'hC);

  logic [N-1:0]       s1, s2, prev, flag, mode, polar;
  logic [DATA_BW-1:0] rdata;

  logic               wr_acc, rd_acc;
  logic               sel_int, sel_mode, sel_polar;
  logic [N-1:0]       wdata_n, w1c;
  logic [N-1:0]       mode_nxt, polar_nxt, cfg_chg;
  logic [N-1:0]       act, flag_nxt, prev_nxt;
  logic [DATA_BW-1:0] rdata_nxt;
  logic               unused_wdata;

  assign unused_wdata = ^bus.bus_wdata;

  // Bus decode and qualified write/read strobes.
  always_comb begin
    wr_acc    = bus.bus_en & bus.bus_wr & bus.is_priviledge;
    rd_acc    = bus.bus_en & ~bus.bus_wr;
    sel_int   = (bus.bus_addr == A_EXTINT);
    sel_mode  = (bus.bus_addr == A_EXTMODE);
    sel_polar = (bus.bus_addr == A_EXTPOLAR);
    wdata_n   = bus.bus_wdata[N-1:0];
  end

  // Per-line next-state: config update, flag set/clear, edge history.
  always_comb begin
    mode_nxt  = (wr_acc & sel_mode)  ? wdata_n : mode;
    polar_nxt = (wr_acc & sel_polar) ? wdata_n : polar;
    cfg_chg   = (mode_nxt ^ mode) | (polar_nxt ^ polar);
    w1c       = (wr_acc & sel_int) ? wdata_n : '0;
    act       = ~(s2 ^ polar);
    // Level lines follow act; edge lines set on a rising act (set beats W1C);
    // any config change on a line clears its flag.
    flag_nxt  = ~cfg_chg & ((~mode & act) |
                            (mode & ((act & ~prev) | (flag & ~w1c))));
    // Using the next polarity for every line equals act on untouched lines
    // and reloads history on re-polarised lines, so no false edge follows.
    prev_nxt  = ~(s2 ^ polar_nxt);
  end

  // Read mux; unmapped addresses and bits above N read zero.
  always_comb begin
    rdata_nxt = '0;
    if (sel_int)        rdata_nxt[N-1:0] = flag;
    else if (sel_mode)  rdata_nxt[N-1:0] = mode;
    else if (sel_polar) rdata_nxt[N-1:0] = polar;
  end

  // State registers; pins idle high through reset so no edge appears at release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= '1;
      s2    <= '1;
      prev  <= '0;
      flag  <= '0;
      mode  <= '0;
      polar <= '0;
      rdata <= '0;
    end else begin
      s1    <= ext_pin;
      s2    <= s1;
      prev  <= prev_nxt;
      flag  <= flag_nxt;
      mode  <= mode_nxt;
      polar <= polar_nxt;
      if (rd_acc) rdata <= rdata_nxt;
    end
  end

  assign bus.bus_rdata = rdata;
  assign vic_eint      = flag;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Self-checking bench for ext_int_ctrl: scoreboard queue of expected values.
module tb_ext_int_ctrl;
  localparam int unsigned N    = 4;
  localparam logic [31:0] BASE = 32'hE01F_C140;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] ext_pin;
  logic [N-1:0] vic_eint;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] rd;

  ext_int_ctrl_if #(.ADDR_BW(32), .DATA_BW(32)) bus_if ();

  ext_int_ctrl #(.N(N), .BASE(BASE), .ADDR_BW(32), .DATA_BW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .ext_pin  (ext_pin),
    .bus      (bus_if),
    .vic_eint (vic_eint)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] data, input logic priv);
    @(negedge clk);
    bus_if.bus_en = 1'b1; bus_if.bus_wr = 1'b1; bus_if.bus_addr = BASE + off;
    bus_if.bus_wdata = data; bus_if.is_priviledge = priv;
    @(negedge clk);
    bus_if.bus_en = 1'b0; bus_if.bus_wr = 1'b0; bus_if.is_priviledge = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] off, output logic [31:0] data);
    @(negedge clk);
    bus_if.bus_en = 1'b1; bus_if.bus_wr = 1'b0; bus_if.bus_addr = BASE + off;
    @(negedge clk);
    bus_if.bus_en = 1'b0;
    data = bus_if.bus_rdata;
  endtask

  task automatic test_reset;
    rst = 1'b0; ext_pin = '1;
    bus_if.bus_en = 1'b0; bus_if.bus_wr = 1'b0; bus_if.bus_addr = '0;
    bus_if.bus_wdata = '0; bus_if.is_priviledge = 1'b0;
    idle(3);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL reset_vic_in got %h want %h", vic_eint, exp_v); end
    rst = 1'b1;
    idle(4);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL reset_vic_out got %h want %h", vic_eint, exp_v); end
    for (int unsigned i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0);
      bus_read(32'(i * 4), rd);
      exp_v = exp_q.pop_front(); checks++;
      if (rd !== exp_v) begin errors++; $display("FAIL reset_read_%0d got %h want %h", i * 4, rd, exp_v); end
    end
  endtask

  task automatic test_level;
    @(negedge clk); ext_pin[0] = 1'b0;
    idle(2);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL level_lat2 got %h want %h", vic_eint, exp_v); end
    idle(1);
    exp_q.push_back(32'h1);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL level_lat3 got %h want %h", vic_eint, exp_v); end
    exp_q.push_back(32'h1);
    bus_write(32'h0, 32'h1, 1'b1);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL level_w1c got %h want %h", vic_eint, exp_v); end
    exp_q.push_back(32'h1);
    bus_read(32'h0, rd);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL level_rd got %h want %h", rd, exp_v); end
    ext_pin[0] = 1'b1;
    idle(2);
    exp_q.push_back(32'h1);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL level_rel2 got %h want %h", vic_eint, exp_v); end
    idle(1);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL level_rel3 got %h want %h", vic_eint, exp_v); end
  endtask

  task automatic test_edge;
    bus_write(32'h8, 32'h2, 1'b1);
    bus_write(32'hC, 32'h2, 1'b1);
    ext_pin[1] = 1'b0;
    idle(4);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL edge_fall got %h want %h", vic_eint, exp_v); end
    @(negedge clk); ext_pin[1] = 1'b1;
    @(negedge clk); ext_pin[1] = 1'b0;
    exp_q.push_back(32'h2);
    idle(4);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL edge_latch got %h want %h", vic_eint, exp_v); end
    exp_q.push_back(32'h2);
    bus_read(32'h0, rd);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL edge_rd got %h want %h", rd, exp_v); end
    exp_q.push_back(32'h0);
    bus_write(32'h0, 32'h2, 1'b1);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL edge_w1c got %h want %h", vic_eint, exp_v); end
    exp_q.push_back(32'h2);
    bus_read(32'h8, rd);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL edge_mode_rd got %h want %h", rd, exp_v); end
    exp_q.push_back(32'h2);
    bus_read(32'hC, rd);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL edge_polar_rd got %h want %h", rd, exp_v); end
  endtask

  task automatic test_simultaneous;
    @(negedge clk); ext_pin[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_if.bus_en = 1'b1; bus_if.bus_wr = 1'b1; bus_if.bus_addr = BASE;
    bus_if.bus_wdata = 32'h2; bus_if.is_priviledge = 1'b1;
    exp_q.push_back(32'h2);
    @(negedge clk);
    bus_if.bus_en = 1'b0; bus_if.bus_wr = 1'b0; bus_if.is_priviledge = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL simul_vic got %h want %h", vic_eint, exp_v); end
    exp_q.push_back(32'h2);
    bus_read(32'h0, rd);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL simul_rd got %h want %h", rd, exp_v); end
    ext_pin[1] = 1'b0;
    idle(4);
    exp_q.push_back(32'h0);
    bus_write(32'h0, 32'h2, 1'b1);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL simul_clr got %h want %h", vic_eint, exp_v); end
  endtask

  task automatic test_polarity;
    ext_pin[2] = 1'b0;
    idle(4);
    exp_q.push_back(32'h4);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL pol_level got %h want %h", vic_eint, exp_v); end
    exp_q.push_back(32'h0);
    bus_write(32'h8, 32'h6, 1'b1);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL pol_modechg got %h want %h", vic_eint, exp_v); end
    bus_write(32'hC, 32'h6, 1'b1);
    exp_q.push_back(32'h0);
    idle(4);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL pol_0to1 got %h want %h", vic_eint, exp_v); end
    bus_write(32'hC, 32'h2, 1'b1);
    exp_q.push_back(32'h0);
    idle(4);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL pol_1to0 got %h want %h", vic_eint, exp_v); end
    bus_write(32'h8, 32'hF, 1'b0);
    exp_q.push_back(32'h6);
    bus_read(32'h8, rd);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL pol_unpriv got %h want %h", rd, exp_v); end
    bus_write(32'h4, 32'hF, 1'b1);
    exp_q.push_back(32'h0);
    bus_read(32'h4, rd);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL unmapped_rd got %h want %h", rd, exp_v); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus_if.bus_en = 1'b1; bus_if.bus_wr = 1'b0; bus_if.bus_addr = BASE + 32'h8;
    exp_q.push_back(32'h6);
    @(negedge clk);
    bus_if.bus_wr = 1'b1; bus_if.bus_wdata = 32'hE; bus_if.is_priviledge = 1'b1;
    @(negedge clk);
    bus_if.bus_en = 1'b0; bus_if.bus_wr = 1'b0; bus_if.is_priviledge = 1'b0;
    rd = bus_if.bus_rdata;
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL b2b_prewrite got %h want %h", rd, exp_v); end
    exp_q.push_back(32'hE);
    bus_read(32'h8, rd);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL b2b_postwrite got %h want %h", rd, exp_v); end
  endtask

  task automatic test_async_reset;
    ext_pin = '1;
    idle(4);
    bus_write(32'h0, 32'hF, 1'b1);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL ar_clear got %h want %h", vic_eint, exp_v); end
    @(negedge clk); ext_pin[3] = 1'b0;
    @(negedge clk); ext_pin[3] = 1'b1;
    exp_q.push_back(32'h8);
    idle(4);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL ar_pending got %h want %h", vic_eint, exp_v); end
    @(posedge clk); #2;
    rst = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL ar_immediate got %h want %h", vic_eint, exp_v); end
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); checks++;
    if (bus_if.bus_rdata !== exp_v) begin errors++; $display("FAIL ar_rdata got %h want %h", bus_if.bus_rdata, exp_v); end
    @(negedge clk); rst = 1'b1;
    exp_q.push_back(32'h0);
    idle(5);
    exp_v = exp_q.pop_front(); checks++;
    if ({28'h0, vic_eint} !== exp_v) begin errors++; $display("FAIL ar_release got %h want %h", vic_eint, exp_v); end
    exp_q.push_back(32'h0);
    bus_read(32'h8, rd);
    exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL ar_mode got %h want %h", rd, exp_v); end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_simultaneous();
    test_polarity();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_int_ctrl.md
# ext_int_ctrl

External interrupt conditioning stage that sits directly upstream of the vectored interrupt controller. It synchronises N asynchronous external interrupt pins and applies per-line level/edge mode and polarity. It holds edge-triggered requests in software-clearable flags and drives the conditioned requests onto the VIC's `vic_intr` source lines. Software reaches it through memory-mapped registers on the system bus.

## Interface

- `N`, 4, number of external interrupt lines (1..32)
- `BASE`, 32'hE01F_C140, byte address of the EXTINT register
- `rst` input 1: reset, asynchronous, active-low
- `clk` input 1: system clock; all state on rising edge
- `ext_pin` input N: raw asynchronous interrupt pins
- `bus_en` input 1: bus access strobe, sampled each rising edge
- `bus_wr` input 1: 1 = write, 0 = read; qualified by `bus_en`
- `bus_addr` input `ADDR_BW`: byte address
- `bus_wdata` input `DATA_BW`: write data
- `is_priviledge` input 1: writes accepted only when 1
- `bus_rdata` output `DATA_BW`: registered read data
- `vic_eint` output N: conditioned requests to VIC `vic_intr` lines, active-high

## Operation

- Register map, word aligned:
  - BASE+0x0 EXTINT: flags. Read returns the flags. Writing 1 to a bit clears that flag, for edge-mode lines only.
  - BASE+0x8 EXTMODE: 0 = level, 1 = edge. Read/write.
  - BASE+0xC EXTPOLAR: 0 = active-low/falling, 1 = active-high/rising. Read/write.
- Other addresses read 0; writes to them are ignored. Bits N..31 read 0.
- Per-line datapath:
  - `ext_pin` passes through a 2-flop synchroniser s1→s2.
  - act = s2 XNOR EXTPOLAR bit, so act = 1 means asserted.
  - prev is the registered act.
- Level mode: flag <= act every cycle. A W1C write has no effect.
- Edge mode: flag set when act & ~prev; flag cleared by a W1C write of 1.
  - If a set and a clear occur in the same cycle, set wins.
- Changing a line's EXTMODE or EXTPOLAR bit by write:
  - That line's flag is cleared.
  - prev is loaded with act recomputed using the new polarity.
  - No spurious edge is flagged on the following cycle.
- `vic_eint` = flags, driven directly from the flag registers.
- A write with `is_priviledge` = 0 is ignored entirely. Reads are always permitted.
- Read: on an edge with `bus_en` & ~`bus_wr`, `bus_rdata` loads the addressed register. It holds its value until the next read.

## Timing

- Reset values:
  - s1 and s2 = all 1s (pins idle high).
  - prev = 0; flags = 0; EXTMODE = 0; EXTPOLAR = 0.
  - `bus_rdata` = 0; `vic_eint` = 0.
- Pin-to-output latency: a pin change set up before edge k gives s2 updated at edge k+1 and the flag at edge k+2. `vic_eint` is visible after edge k+2, i.e. 3 edges counting the sampling edge.
- Minimum pulse width for edge detection is 1 clock period of stable level. Shorter pulses may be missed.
- Write effects land at the edge where `bus_en` & `bus_wr` & `is_priviledge` are sampled:
  - A W1C-cleared flag reads 0 and `vic_eint` deasserts after that edge.
  - If an edge is detected at the same edge, the flag stays 1.
- Read latency is 1 cycle: `bus_rdata` is valid after the sampling edge. A back-to-back read and write to the same register returns the pre-write value.
- Reset is asynchronous and may occur mid-operation. Pending flags are lost, `vic_eint` drops to 0 immediately, and no output glitches high on reset release.
- A pin held low through reset release with polarity 0 registers as a falling edge 2 edges after release, and the flag sets at the next edge. This is intended.

## Test plan

- Reset with all pins high, EXTMODE = 0, EXTPOLAR = 0 → `vic_eint` = 0. Reads of 0x0/0x8/0xC return 0.
- Level, active-low: drive pin0 low at edge 10 → `vic_eint[0]` = 1 after edge 12. Write EXTINT = 1 → stays 1. Release pin0 → 0 after 3 edges.
- Edge, rising: EXTMODE = 0x2, EXTPOLAR = 0x2, pulse pin1 high for 1 cycle → `vic_eint[1]` latched 1. Write EXTINT = 0x2 → 0 on the next cycle.
- Simultaneous set/clear: W1C on bit1 on the same edge that a rising edge is detected → flag reads 1.
- Polarity change: pin2 low in edge mode, write EXTPOLAR bit2 0→1 → no flag set. Privileged = 0 write of EXTMODE = 0xF → register unchanged.
- Async reset mid-pending: flag3 = 1, assert rst between edges → `vic_eint` = 0 immediately, stays 0 after release with pins idle.
